run_ctrl: RTL and testbench

- Front-panel sequencer for the 8-bit accumulator CPU.
- Loads a program into datapath memory from the Nin switches, one word per enter press.
- Releases the CPU in free-run or single-step mode, gating it with a clock enable, and counts executed cycles.
- Detects halt or watchdog timeout.
- Sits between the board buttons/switches and the CPU's control unit, datapath and memory write port.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/btn_sync_edge.sv | 29 ++
 rtl/run_ctrl.sv | 141 ++++++++++++++
 tb/tb_run_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the front-panel run controller.
package run_ctrl_pkg;

  localparam int ADDR_W_DEF    = 5;
  localparam int DATA_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 32;
  localparam int CNT_W         = 16;

  // The encoding is also the state number shown on the display.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PRESET = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEPW  = 3'd4,
    ST_STEP   = 3'd5,
    ST_HALTED = 3'd6,
    ST_TOUT   = 3'd7
  } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button, followed by a rising-edge detector
// that yields one single-cycle pulse per press, however long it is held.
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  // Synchronizer chain plus one delayed copy for edge detection.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/run_ctrl.sv
// Front-panel sequencer for the 8-bit accumulator CPU: loads program words
// from the switches, releases the CPU in free-run or single-step mode through
// a clock enable, counts enabled cycles and watches for halt or a hung run.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic              start,
  input  logic              load,
  input  logic              step_mode,
  input  logic [DATA_W-1:0] Nin,
  input  logic              halt,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_we,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              timeout,
  output logic [2:0]        state_no
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t state, state_next;
  logic   enter_p, start_p, load_p;
  logic   step_s1, step_s;

  btn_sync_edge u_enter (.clock(clock), .reset(reset), .din(enter), .pulse(enter_p));
  btn_sync_edge u_start (.clock(clock), .reset(reset), .din(start), .pulse(start_p));
  btn_sync_edge u_load  (.clock(clock), .reset(reset), .din(load),  .pulse(load_p));

  // step_mode is a level, so it only needs synchronizing, not edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_s1 <= 1'b0;
      step_s  <= 1'b0;
    end else begin
      step_s1 <= step_mode;
      step_s  <= step_s1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets its default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_p)     state_next = ST_PRESET;
        else if (load_p) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        // start always wins; a partial load leaves the rest of memory alone
        if (start_p)                            state_next = ST_PRESET;
        else if (ld_we && ld_addr == LAST_ADDR) state_next = ST_IDLE;
      end
      ST_PRESET: state_next = step_s ? ST_STEPW : ST_RUN;
      ST_RUN: begin
        if (halt)                          state_next = ST_HALTED;
        else if (cycle_cnt == TIMEOUT_CNT) state_next = ST_TOUT;
        else if (step_s)                   state_next = ST_STEPW;
      end
      ST_STEPW: begin
        if (halt)         state_next = ST_HALTED;
        else if (enter_p) state_next = ST_STEP;
        else if (!step_s) state_next = ST_RUN;
      end
      ST_STEP: state_next = halt ? ST_HALTED : ST_STEPW;
      ST_HALTED, ST_TOUT: begin
        if (start_p)     state_next = ST_PRESET;
        else if (load_p) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CPU controls decoded from the state register alone.
  always_comb begin
    cpu_en    = (state == ST_RUN) || (state == ST_STEP);
    cpu_reset = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_PRESET);
    state_no  = state;
  end

  // Loader: capture switches on enter, strobe ld_we one cycle, then advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_addr <= '0;
      ld_data <= '0;
      ld_we   <= 1'b0;
    end else begin
      ld_we <= 1'b0;
      // the ld_we guard keeps a write from straddling the exit from LOAD
      if (state == ST_LOAD && enter_p && !start_p && !ld_we) begin
        ld_data <= Nin;
        ld_we   <= 1'b1;
      end
      if (ld_we)
        ld_addr <= (ld_addr == LAST_ADDR) ? '0 : ld_addr + 1'b1;
      else if (state != ST_LOAD && state_next == ST_LOAD)
        ld_addr <= '0;
    end
  end

  // Enabled-cycle counter, saturating, cleared only in PRESET.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cycle_cnt <= '0;
    else if (state == ST_PRESET)
      cycle_cnt <= '0;
    else if (cpu_en && cycle_cnt != CNT_MAX)
      cycle_cnt <= cycle_cnt + 1'b1;
  end

  // Watchdog flag: set on the trip into TOUT, held until the next PRESET.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      timeout <= 1'b0;
    else if (state == ST_PRESET)
      timeout <= 1'b0;
    else if (state == ST_RUN && state_next == ST_TOUT)
      timeout <= 1'b1;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: loader writes go through a scoreboard
// queue, the rest is checked with short directed sequences.
module tb_run_ctrl;

  localparam int TB_TIMEOUT = 25;
  localparam int B_ENTER = 0, B_START = 1, B_LOAD = 2;

  logic        clock = 1'b0;
  logic        reset, enter, start, load, step_mode, halt;
  logic [7:0]  Nin;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_we, cpu_en, cpu_reset, timeout;
  logic [15:0] cycle_cnt;
  logic [2:0]  state_no;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int en_cycles = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0] nin;
    logic [4:0] exp_addr;
  } load_vec_t;
  load_vec_t vecs[3];

  run_ctrl #(.MEM_DEPTH(32), .ADDR_W(5), .DATA_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .enter(enter), .start(start), .load(load),
    .step_mode(step_mode), .Nin(Nin), .halt(halt), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_we(ld_we), .cpu_en(cpu_en), .cpu_reset(cpu_reset),
    .cycle_cnt(cycle_cnt), .timeout(timeout), .state_no(state_no)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      B_ENTER: enter = 1'b1;
      B_START: start = 1'b1;
      default: load  = 1'b1;
    endcase
    repeat (hold) tick();
    enter = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    repeat (4) tick();
  endtask

  task automatic wait_state(input string name, input logic [2:0] target, input int budget);
    int k = 0;
    while (state_no !== target && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(state_no), 32'(target));
  endtask

  // Scoreboard: every loader write is compared against the queued expectation.
  always @(negedge clock) begin
    if (cpu_en === 1'b1) en_cycles++;
    if (ld_we === 1'b1) begin
      wr_cnt++;
      check("we_only_in_load", 32'(state_no), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(ld_addr), 32'h1f_ffff);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(ld_addr), 32'(e.addr));
        check("write_data", 32'(ld_data), 32'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{nin: 8'hA1, exp_addr: 5'd0};
    vecs[1] = '{nin: 8'hA2, exp_addr: 5'd1};
    vecs[2] = '{nin: 8'hA3, exp_addr: 5'd2};

    reset = 1'b0; enter = 1'b0; start = 1'b0; load = 1'b0;
    step_mode = 1'b0; halt = 1'b0; Nin = 8'h00;
    repeat (3) tick();

    // Reset values
    check("rst_state",     32'(state_no),  32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_cpu_en",    32'(cpu_en),    32'd0);
    check("rst_ld_we",     32'(ld_we),     32'd0);
    check("rst_ld_addr",   32'(ld_addr),   32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_timeout",   32'(timeout),   32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Full program load: 32 words, data = addr + 0x10
    press(B_LOAD, 3);
    wait_state("enter_load", 3'd1, 10);
    for (int i = 0; i < 32; i++) begin
      Nin = 8'(i + 8'h10);
      exp_q.push_back('{addr: 5'(i), data: Nin});
      press(B_ENTER, 3);
    end
    check("full_load_writes", 32'(wr_cnt), 32'd32);
    check("full_load_idle",   32'(state_no), 32'd0);
    check("full_load_addr",   32'(ld_addr),  32'd0);

    // Partial load then start
    press(B_LOAD, 3);
    wait_state("enter_load2", 3'd1, 10);
    for (int i = 0; i < 3; i++) begin
      Nin = vecs[i].nin;
      exp_q.push_back('{addr: vecs[i].exp_addr, data: vecs[i].nin});
      press(B_ENTER, 3);
    end
    check("partial_writes", 32'(wr_cnt), 32'd35);
    start = 1'b1;
    wait_state("preset", 3'd2, 10);
    check("preset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("preset_cpu_en",    32'(cpu_en),    32'd0);
    tick();
    start = 1'b0;
    check("run_state",     32'(state_no),  32'd3);
    check("run_cpu_en",    32'(cpu_en),    32'd1);
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("run_cnt0",      32'(cycle_cnt), 32'd0);
    tick();
    check("run_cnt1",      32'(cycle_cnt), 32'd1);

    // Halt raised during the 20th enabled cycle
    k = 0;
    while (cycle_cnt != 16'd19 && k < 100) begin tick(); k++; end
    check("reach_cnt19", 32'(cycle_cnt), 32'd19);
    halt = 1'b1;
    tick();
    check("halted_state",  32'(state_no),  32'd6);
    check("halted_cpu_en", 32'(cpu_en),    32'd0);
    check("halted_cpu_rst",32'(cpu_reset), 32'd0);
    check("halted_cnt",    32'(cycle_cnt), 32'd20);
    halt = 1'b0;
    repeat (3) tick();
    check("halted_cnt_frozen", 32'(cycle_cnt), 32'd20);

    // Restart, then let the watchdog trip
    start = 1'b1;
    wait_state("preset2", 3'd2, 10);
    tick();
    start = 1'b0;
    check("restart_cnt0", 32'(cycle_cnt), 32'd0);
    wait_state("tout_state", 3'd7, 100);
    check("tout_flag",   32'(timeout),   32'd1);
    // the cycle that sees cnt==TIMEOUT is itself enabled, so one more count
    check("tout_cnt",    32'(cycle_cnt), 32'(TB_TIMEOUT + 1));
    check("tout_cpu_en", 32'(cpu_en),    32'd0);
    repeat (3) tick();
    check("tout_held",   32'(timeout),   32'd1);

    // Single step: start from TOUT with step_mode set
    step_mode = 1'b1;
    repeat (3) tick();
    press(B_START, 3);
    wait_state("stepw_state", 3'd4, 10);
    check("stepw_timeout_clr", 32'(timeout),   32'd0);
    check("stepw_cnt0",        32'(cycle_cnt), 32'd0);
    check("stepw_cpu_en",      32'(cpu_en),    32'd0);
    en_cycles = 0;
    for (int i = 0; i < 4; i++) press(B_ENTER, 5);
    check("step_pulses", 32'(en_cycles), 32'd4);
    check("step_cnt",    32'(cycle_cnt), 32'd4);
    check("step_back_w", 32'(state_no),  32'd4);
    step_mode = 1'b0;
    wait_state("step_to_run", 3'd3, 10);
    check("step_run_en", 32'(cpu_en), 32'd1);
    halt = 1'b1;
    tick();
    check("halt_from_run", 32'(state_no), 32'd6);
    halt = 1'b0;

    // Load from HALTED clears the address, then reset mid-write
    press(B_LOAD, 3);
    wait_state("load_from_halt", 3'd1, 10);
    check("load_addr_clr", 32'(ld_addr), 32'd0);
    Nin = 8'h5A;
    enter = 1'b1;
    k = 0;
    while (ld_we !== 1'b1 && k < 10) begin tick(); k++; end
    check("we_seen_before_reset", 32'(ld_we), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_state",     32'(state_no),  32'd0);
    check("async_rst_we",        32'(ld_we),     32'd0);
    check("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("async_rst_addr",      32'(ld_addr),   32'd0);
    check("async_rst_cnt",       32'(cycle_cnt), 32'd0);
    enter = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();

    // start and load together in IDLE: start wins
    start = 1'b1;
    load  = 1'b1;
    k = 0;
    while (state_no === 3'd0 && k < 10) begin tick(); k++; end
    check("simul_preset", 32'(state_no), 32'd2);
    tick();
    check("simul_run", 32'(state_no), 32'd3);
    start = 1'b0;
    load  = 1'b0;
    repeat (2) tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(wr_cnt), 32'd35);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
